// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store front-end between the EX/MEM pipeline register and a
//   word-organised data memory. Byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW
//   requests become word accesses. Sub-word stores use a two-cycle
//   read-modify-write that stalls the pipeline for one cycle. Load results
//   are registered and extended. Misaligned or illegal requests raise a
//   registered exception pulse.
//
// Ports
//   Clk, Rst                 clock (rising edge), async active-high reset
//   req_valid/req_write      memory instruction present / 1 = store
//   req_size                 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned             zero-extend loads when set
//   req_addr, req_wdata      byte address, store data (sub-word in low bits)
//   mem_addr                 word address = req_addr[ADDR_W+1:2]
//   mem_read, mem_write      data memory strobes
//   mem_wdata, mem_rdata     data memory write / read data
//   stall                    freeze upstream pipeline registers this cycle
//   load_data, load_valid    registered load result and its 1-cycle strobe
//   misalign_exc, exc_addr   1-cycle fault pulse, faulting byte address

module mem_access_unit #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              misalign_exc,
    output logic [DATA_W-1:0] exc_addr
);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t            state;

    // Latched sub-word store, consumed in MERGE
    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_lane;
    logic              lat_half;
    logic [15:0]       lat_wdata;
    logic [DATA_W-1:0] merge_q;

    logic              illegal;
    logic              active;
    logic              is_load;
    logic              is_sw;
    logic              is_sub_store;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rdata_shift;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [DATA_W-1:0] load_ext;

    // Address bits beyond the memory are deliberately discarded (32 KB wrap)
    logic              unused_addr_hi;
    assign unused_addr_hi = ^req_addr[DATA_W-1:ADDR_W+2];

    always_comb begin
        illegal = 1'b0;
        unique case (req_size)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = req_addr[0];
            2'b10:   illegal = (req_addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // Requests are only honoured from IDLE and never while reset is held
    assign active       = req_valid && !Rst && (state == IDLE) && !illegal;
    assign is_load      = active && !req_write;
    assign is_sw        = active && req_write && (req_size == 2'b10);
    assign is_sub_store = active && req_write && (req_size != 2'b10);

    // Replace only the target lane(s) of the word read in the first cycle
    always_comb begin
        merged = merge_q;
        if (lat_half) begin
            if (lat_lane[1]) merged[31:16] = lat_wdata;
            else             merged[15:0]  = lat_wdata;
        end else begin
            unique case (lat_lane)
                2'd0:    merged[7:0]   = lat_wdata[7:0];
                2'd1:    merged[15:8]  = lat_wdata[7:0];
                2'd2:    merged[23:16] = lat_wdata[7:0];
                default: merged[31:24] = lat_wdata[7:0];
            endcase
        end
    end

    // Lane selection and extension for loads
    always_comb begin
        rdata_shift = mem_rdata >> {req_addr[1:0], 3'b000};
        sel_byte    = rdata_shift[7:0];
        sel_half    = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (req_size)
            2'b00:   load_ext = req_unsigned ? {24'h000000, sel_byte}
                                             : {{24{sel_byte[7]}}, sel_byte};
            2'b01:   load_ext = req_unsigned ? {16'h0000, sel_half}
                                             : {{16{sel_half[15]}}, sel_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Memory-side strobes; reset forces all of them low immediately, which
    // abandons a write pending in MERGE
    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        stall     = 1'b0;
        if (!Rst) begin
            if (state == MERGE) begin
                mem_addr  = lat_addr;
                mem_write = 1'b1;
                mem_wdata = merged;
            end else if (req_valid) begin
                mem_addr = req_addr[ADDR_W+1:2];
                if (is_load) begin
                    mem_read = 1'b1;
                end
                if (is_sw) begin
                    mem_write = 1'b1;
                    mem_wdata = req_wdata;
                end
                if (is_sub_store) begin
                    mem_read = 1'b1;
                    stall    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= IDLE;
            lat_addr     <= '0;
            lat_lane     <= '0;
            lat_half     <= 1'b0;
            lat_wdata    <= '0;
            merge_q      <= '0;
            load_data    <= '0;
            load_valid   <= 1'b0;
            misalign_exc <= 1'b0;
            exc_addr     <= '0;
        end else begin
            load_valid   <= 1'b0;
            misalign_exc <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            misalign_exc <= 1'b1;
                            exc_addr     <= req_addr;
                        end else if (!req_write) begin
                            load_valid <= 1'b1;
                            load_data  <= load_ext;
                        end else if (req_size != 2'b10) begin
                            merge_q   <= mem_rdata;
                            lat_addr  <= req_addr[ADDR_W+1:2];
                            lat_lane  <= req_addr[1:0];
                            lat_half  <= req_size[0];
                            lat_wdata <= req_wdata[15:0];
                            state     <= MERGE;
                        end
                    end
                end
                MERGE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [12:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign_exc;
    logic [31:0] exc_addr;

    mem_access_unit #(.ADDR_W(13), .DATA_W(32)) dut (
        .Clk(Clk), .Rst(Rst),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall),
        .load_data(load_data), .load_valid(load_valid),
        .misalign_exc(misalign_exc), .exc_addr(exc_addr)
    );

    always #5 Clk = ~Clk;

    // Plain synchronous-write, combinational-read data memory
    logic [31:0] mem [0:8191];
    initial for (int i = 0; i < 8192; i++) mem[i] = '0;
    always @(posedge Clk) if (mem_write) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_read ? mem[mem_addr] : 32'h0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ld_q[$];
    logic [31:0] exc_q[$];
    logic [12:0] wa_q[$];
    logic [31:0] wd_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT presents one
    always @(negedge Clk) begin
        if (load_valid === 1'b1) begin
            if (ld_q.size() == 0) check("spurious load_valid", {31'b0, load_valid}, 32'h0);
            else                  check("load_data", load_data, ld_q.pop_front());
        end
        if (misalign_exc === 1'b1) begin
            if (exc_q.size() == 0) check("spurious misalign_exc", {31'b0, misalign_exc}, 32'h0);
            else                   check("exc_addr", exc_addr, exc_q.pop_front());
        end
        if (mem_write === 1'b1) begin
            if (wa_q.size() == 0) check("spurious mem_write", {31'b0, mem_write}, 32'h0);
            else begin
                check("mem_write addr", {19'b0, mem_addr}, {19'b0, wa_q.pop_front()});
                check("mem_write data", mem_wdata, wd_q.pop_front());
            end
        end
    end

    // Present a request for one cycle; returns at the negedge of that cycle
    task automatic req(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
        @(posedge Clk); #1;
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_unsigned = u; req_addr = a; req_wdata = d;
        @(negedge Clk);
    endtask

    task automatic idle();
        @(posedge Clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic chk_strobes(input string name, input logic rd, input logic wr, input logic st);
        check(name, {29'b0, mem_read, mem_write, stall}, {29'b0, rd, wr, st});
    endtask

    task automatic chk_all_zero(input string name);
        check({name, " strobes"}, {27'b0, mem_read, mem_write, stall, load_valid, misalign_exc}, 32'h0);
        check({name, " mem_addr"}, {19'b0, mem_addr}, 32'h0);
        check({name, " mem_wdata"}, mem_wdata, 32'h0);
        check({name, " load_data"}, load_data, 32'h0);
        check({name, " exc_addr"}, exc_addr, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a request pending: everything must read 0
        #2 Rst = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        @(negedge Clk); @(negedge Clk);
        chk_all_zero("reset");
        @(posedge Clk); #1;
        Rst = 1'b0; req_valid = 1'b0;
        @(negedge Clk);
        chk_strobes("idle strobes", 1'b0, 1'b0, 1'b0);

        // SW then LW
        wa_q.push_back(13'd4); wd_q.push_back(32'hDEADBEEF);
        req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        chk_strobes("sw strobes", 1'b0, 1'b1, 1'b0);
        check("sw mem_addr", {19'b0, mem_addr}, 32'd4);
        ld_q.push_back(32'hDEADBEEF);
        req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk_strobes("lw strobes", 1'b1, 1'b0, 1'b0);

        // Sub-word loads with sign/zero extension
        ld_q.push_back(32'hFFFFFFDE); req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        ld_q.push_back(32'h000000DE); req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        ld_q.push_back(32'hFFFFBEEF); req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        ld_q.push_back(32'h0000DEAD); req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);

        // SB read-modify-write, then back-to-back LW of the same word
        req(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055);
        chk_strobes("sb rmw read", 1'b1, 1'b0, 1'b1);
        wa_q.push_back(13'd4); wd_q.push_back(32'hDEAD55EF);
        @(posedge Clk); @(negedge Clk);
        chk_strobes("sb rmw write", 1'b0, 1'b1, 1'b0);
        ld_q.push_back(32'hDEAD55EF); req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        ld_q.push_back(32'h00000055); req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);

        // Misaligned / illegal requests
        exc_q.push_back(32'h13); req(1'b1, 2'b01, 1'b0, 32'h13, 32'h1234);
        chk_strobes("sh misaligned", 1'b0, 1'b0, 1'b0);
        exc_q.push_back(32'h0E); req(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0);
        chk_strobes("lw misaligned", 1'b0, 1'b0, 1'b0);
        exc_q.push_back(32'h20); req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        chk_strobes("size 11", 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge Clk);
        check("exc_addr holds", exc_addr, 32'h20);

        // SH with reset asserted during MERGE: write abandoned
        req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
        chk_strobes("sh rmw read", 1'b1, 1'b0, 1'b1);
        @(posedge Clk); #1;
        Rst = 1'b1;
        @(negedge Clk);
        chk_all_zero("reset in merge");
        @(posedge Clk); #1;
        Rst = 1'b0; req_valid = 1'b0;
        ld_q.push_back(32'hDEAD55EF); req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // Address wrap: 0x8010 maps to word 4
        wa_q.push_back(13'd4); wd_q.push_back(32'hA5A50F0F);
        req(1'b1, 2'b10, 1'b0, 32'h8010, 32'hA5A50F0F);
        check("wrap mem_addr", {19'b0, mem_addr}, 32'd4);
        chk_strobes("wrap strobes", 1'b0, 1'b1, 1'b0);
        ld_q.push_back(32'hA5A50F0F); req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        idle();
        repeat (4) @(negedge Clk);
        check("loads drained", ld_q.size(), 32'd0);
        check("faults drained", exc_q.size(), 32'd0);
        check("writes drained", wa_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end between the EX/MEM pipeline register and the word-organised data memory.
- Converts byte-addressed MIPS load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) into word accesses.
- Performs two-cycle read-modify-write for sub-word stores, stalling the pipeline for one cycle.
- Registers load results, with sign/zero extension, for the MEM/WB stage, and flags misaligned accesses.

Parameters:
- ADDR_W, 13: word-address width driven to data memory (8192 words).
- DATA_W, 32: data width; fixed at 32, not intended to be changed.

Ports:
- Clk  input  1  system clock, rising-edge.
- Rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  EX/MEM holds a memory instruction this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
- req_addr  input  32  byte address from the ALU.
- req_wdata  input  32  store data; the sub-word is in the low bits.
- mem_addr  output  ADDR_W  word address to data memory, equal to req_addr[ADDR_W+1:2].
- mem_read  output  1  MemRead to data memory.
- mem_write  output  1  MemWrite to data memory.
- mem_wdata  output  32  Write_data to data memory.
- mem_rdata  input  32  Read_data from data memory (combinational, 0 when mem_read=0).
- stall  output  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers this cycle.
- load_data  output  32  registered, extended load result.
- load_valid  output  1  load_data is valid this cycle (1-cycle pulse).
- misalign_exc  output  1  registered 1-cycle pulse: the last request was misaligned or illegal.
- exc_addr  output  32  byte address of the faulting request; holds until the next fault.

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - load_data, exc_addr, merge register and latched request fields are cleared to 0.
  - load_valid and misalign_exc are cleared to 0.
  - Combinational outputs are then 0 because state is IDLE and req_valid is ignored while Rst=1.
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k]; halfword h occupies bits [16h+15:16h].
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 32 KB.
- A request is illegal when any of the following holds:
  - req_size=11;
  - req_size=01 and addr[0]=1;
  - req_size=10 and addr[1:0]!=0.
- For an illegal request:
  - mem_read=0, mem_write=0, stall=0, no state change;
  - next edge: misalign_exc=1 and exc_addr=req_addr;
  - load_valid=0.
- States are IDLE and MERGE.
- IDLE, req_valid=0: mem_read=0, mem_write=0, stall=0.
- IDLE, legal load:
  - mem_read=1, mem_addr from req_addr, stall=0.
  - At the edge, load_data is loaded with the selected lane of mem_rdata, extended to 32 bits, and load_valid=1 for exactly one cycle.
  - Latency is 1 cycle, aligned with MEM/WB.
- IDLE, legal SW: mem_write=1 and mem_wdata=req_wdata in the same cycle; stall=0; remain in IDLE.
- IDLE, legal SB/SH:
  - mem_read=1 and stall=1.
  - At the edge: capture mem_rdata into the merge register; latch address, lane and data; go to MERGE.
- MERGE:
  - mem_addr comes from the latched address.
  - mem_write=1, with mem_wdata equal to the merge register with only the target lane(s) replaced.
  - mem_read=0, stall=0.
  - Go to IDLE.
  - req_* inputs are ignored; the pipeline advances normally after this cycle.
- The pipeline holds req_* stable while stall=1. A request observed in the cycle after MERGE is a new instruction.
- Load immediately after a sub-word store to the same word: the write commits at the MERGE edge, so the load in the next cycle reads the merged value. No forwarding is needed.
- load_valid and misalign_exc are 0 in any cycle not following a qualifying request. load_data holds its value otherwise.
- Reset during MERGE: the write is abandoned and memory is unchanged, since reset forces mem_write low immediately.

Test Plan:
- Reset, then SW 0xDEADBEEF to addr 0x10, then LW 0x10: mem_write pulses with mem_addr=4; the following cycle load_valid=1 and load_data=0xDEADBEEF; stall stays 0 throughout.
- Word 4 = 0xDEADBEEF. Loads at 0x13: LB gives 0xFFFFFFDE, LBU gives 0x000000DE. LH at 0x10 gives 0xFFFFBEEF; LHU at 0x12 gives 0x0000DEAD.
- Word 4 = 0xDEADBEEF. SB 0x55 at 0x11: stall=1 for one cycle, then mem_write with mem_wdata=0xDEAD55EF. A back-to-back LW 0x10 returns 0xDEAD55EF.
- SH at 0x13, LW at 0x0E, and size=11 at 0x20: each produces no mem_read or mem_write, a misalign_exc pulse the next cycle, and exc_addr of 0x13, 0x0E and 0x20 respectively.
- SH 0x1234 at 0x12 with Rst asserted during MERGE: mem_write is never asserted and a later LW 0x10 returns the original word. All outputs read 0 during reset.
- SW to addr 0x8010: mem_addr=4, confirming wrap-around; load_valid is never asserted for stores.
